regfile_sb: RTL and testbench

- Parametrised, scoreboarded integer register file; successor to the 2-read/1-write core regfile.
- Configurable read-port and write-port counts, with per-register busy (scoreboard) bits reserved at issue and cleared at writeback.
- Per-port read-valid, optional same-cycle write-to-read bypass.
- Sits between decode/issue (reads and reservations) and writeback (writes) in the pipelined RISC-V core.

---
 rtl/regfile_sb.sv | 114 +++++++++++
 tb/tb_regfile_sb.sv | 427 ++++++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/regfile_sb.sv
// regfile_sb: scoreboarded register file with NUM_RD read and NUM_WR write ports; x0 reads as zero.
// Optional same-cycle write-to-read bypass is enabled by defining REGFILE_SB_BYPASS_EN.
module regfile_sb #(
  parameter  int WIDTH  = 32,
  parameter  int SIZE   = 32,
  parameter  int NUM_RD = 2,
  parameter  int NUM_WR = 2,
  localparam int IW     = $clog2(SIZE)
) (
  input  logic                    clk,
  input  logic                    reset,
  input  logic [NUM_WR-1:0]       wr_en,
  input  logic [NUM_WR*IW-1:0]    wr_index,
  input  logic [NUM_WR*WIDTH-1:0] wr_data,
  input  logic [NUM_RD-1:0]       rd_en,
  input  logic [NUM_RD*IW-1:0]    rd_index,
  output logic [NUM_RD*WIDTH-1:0] rd_data,
  output logic [NUM_RD-1:0]       rd_valid,
  input  logic                    rsv_en,
  input  logic [IW-1:0]           rsv_index,
  output logic                    rsv_ready,
  output logic [IW-1:0]           busy_cnt
);

  logic [WIDTH-1:0] file_q [SIZE];
  logic [SIZE-1:0]  busy_q, busy_d;
  logic [IW-1:0]    busy_cnt_q, busy_cnt_d;

  logic [SIZE-1:0]  wr_hit;
  logic [WIDTH-1:0] wr_val [SIZE];
  logic             rsv_ok;
  logic [SIZE-1:0]  rsv_hit;
  logic [SIZE-1:0]  clr_mask;
  logic [IW-1:0]    clr_cnt;
  logic [IW-1:0]    rd_idx;

  // Merge write ports per register; later ports overwrite earlier ones, so the highest port wins.
  always_comb begin
    wr_hit = '0;
    for (int i = 0; i < SIZE; i++) begin
      wr_val[i] = '0;
    end
    for (int k = 0; k < NUM_WR; k++) begin
      if (wr_en[k] && (wr_index[k*IW +: IW] != '0)) begin
        wr_hit[wr_index[k*IW +: IW]] = 1'b1;
        wr_val[wr_index[k*IW +: IW]] = wr_data[k*WIDTH +: WIDTH];
      end
    end
  end

  // A reservation sets busy after any same-cycle clear, so it wins over writeback.
  always_comb begin
    rsv_ok  = rsv_en && (rsv_index != '0) && !busy_q[rsv_index];
    rsv_hit = '0;
    if (rsv_ok) begin
      rsv_hit[rsv_index] = 1'b1;
    end
    busy_d   = (busy_q & ~wr_hit) | rsv_hit;
    clr_mask = busy_q & wr_hit & ~rsv_hit;
    clr_cnt  = '0;
    for (int i = 0; i < SIZE; i++) begin
      clr_cnt = clr_cnt + IW'(clr_mask[i]);
    end
    busy_cnt_d = busy_cnt_q + IW'(rsv_ok) - clr_cnt;
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      for (int i = 0; i < SIZE; i++) begin
        file_q[i] <= '0;
      end
      busy_q     <= '0;
      busy_cnt_q <= '0;
    end else begin
      for (int i = 1; i < SIZE; i++) begin
        if (wr_hit[i]) begin
          file_q[i] <= wr_val[i];
        end
      end
      busy_q     <= busy_d;
      busy_cnt_q <= busy_cnt_d;
    end
  end

  always_comb begin
    rd_data  = '0;
    rd_valid = '0;
    rd_idx   = '0;
    for (int j = 0; j < NUM_RD; j++) begin
      rd_idx = rd_index[j*IW +: IW];
      if (rd_en[j]) begin
        if (rd_idx == '0) begin
          rd_valid[j] = 1'b1;
        end else begin
          rd_data[j*WIDTH +: WIDTH] = file_q[rd_idx];
          rd_valid[j]               = !busy_q[rd_idx];
`ifdef REGFILE_SB_BYPASS_EN
          // Reset forces zero read data, so the bypass is suppressed while it is held.
          for (int k = 0; k < NUM_WR; k++) begin
            if (!reset && wr_en[k] && (wr_index[k*IW +: IW] == rd_idx)) begin
              rd_data[j*WIDTH +: WIDTH] = wr_data[k*WIDTH +: WIDTH];
              rd_valid[j]               = 1'b1;
            end
          end
`endif
        end
      end
    end
  end

  assign rsv_ready = rsv_ok;
  assign busy_cnt  = busy_cnt_q;

endmodule

// File: tb/tb_regfile_sb.sv
// Self-checking bench for regfile_sb: read expectations go through a scoreboard queue fed by a reference model.
module tb_regfile_sb;
  localparam int WIDTH  = 32;
  localparam int SIZE   = 32;
  localparam int NUM_RD = 2;
  localparam int NUM_WR = 2;
  localparam int IW     = 5;

  logic                    clk = 1'b0;
  logic                    reset;
  logic [NUM_WR-1:0]       wr_en;
  logic [NUM_WR*IW-1:0]    wr_index;
  logic [NUM_WR*WIDTH-1:0] wr_data;
  logic [NUM_RD-1:0]       rd_en;
  logic [NUM_RD*IW-1:0]    rd_index;
  logic [NUM_RD*WIDTH-1:0] rd_data;
  logic [NUM_RD-1:0]       rd_valid;
  logic                    rsv_en;
  logic [IW-1:0]           rsv_index;
  logic                    rsv_ready;
  logic [IW-1:0]           busy_cnt;

  int checks = 0;
  int errors = 0;

  logic [WIDTH-1:0] m_file [SIZE];
  logic             m_busy [SIZE];

  typedef struct {
    int               port;
    logic [WIDTH-1:0] data;
    logic             valid;
  } rd_exp_t;

  rd_exp_t sb[$];

  regfile_sb #(.WIDTH(WIDTH), .SIZE(SIZE), .NUM_RD(NUM_RD), .NUM_WR(NUM_WR)) dut (
    .clk(clk), .reset(reset),
    .wr_en(wr_en), .wr_index(wr_index), .wr_data(wr_data),
    .rd_en(rd_en), .rd_index(rd_index), .rd_data(rd_data), .rd_valid(rd_valid),
    .rsv_en(rsv_en), .rsv_index(rsv_index), .rsv_ready(rsv_ready),
    .busy_cnt(busy_cnt)
  );

  always #5 clk = ~clk;

  function automatic void model_clear();
    for (int i = 0; i < SIZE; i++) begin
      m_file[i] = '0;
      m_busy[i] = 1'b0;
    end
  endfunction

  function automatic int model_cnt();
    int n = 0;
    for (int i = 0; i < SIZE; i++) n += int'(m_busy[i]);
    return n;
  endfunction

  function automatic logic model_rsv_ok();
    return rsv_en && (rsv_index != '0) && !m_busy[rsv_index];
  endfunction

  function automatic rd_exp_t model_read(int port);
    rd_exp_t e;
    logic [IW-1:0] idx;
    idx    = rd_index[port*IW +: IW];
    e.port = port;
    if (!rd_en[port]) begin
      e.data = '0; e.valid = 1'b0;
    end else if (idx == '0) begin
      e.data = '0; e.valid = 1'b1;
    end else begin
      e.data  = m_file[idx];
      e.valid = !m_busy[idx];
`ifdef REGFILE_SB_BYPASS_EN
      if (!reset) begin
        for (int k = 0; k < NUM_WR; k++) begin
          if (wr_en[k] && wr_index[k*IW +: IW] == idx) begin
            e.data  = wr_data[k*WIDTH +: WIDTH];
            e.valid = 1'b1;
          end
        end
      end
`endif
    end
    return e;
  endfunction

  task automatic idle();
    wr_en = '0; wr_index = '0; wr_data = '0;
    rd_en = '0; rd_index = '0;
    rsv_en = 1'b0; rsv_index = '0;
  endtask

  task automatic set_wr(int k, logic en, int idx, logic [WIDTH-1:0] d);
    wr_en[k]                  = en;
    wr_index[k*IW +: IW]      = IW'(idx);
    wr_data[k*WIDTH +: WIDTH] = d;
  endtask

  task automatic set_rd(int j, logic en, int idx);
    rd_en[j]             = en;
    rd_index[j*IW +: IW] = IW'(idx);
  endtask

  task automatic set_rsv(logic en, int idx);
    rsv_en    = en;
    rsv_index = IW'(idx);
  endtask

  task automatic push_reads();
    for (int j = 0; j < NUM_RD; j++) sb.push_back(model_read(j));
  endtask

  // Apply this cycle's inputs to the model, then let the DUT take the same edge.
  task automatic tick();
    logic acc;
    logic [IW-1:0] wi;
    acc = model_rsv_ok();
    for (int k = 0; k < NUM_WR; k++) begin
      wi = wr_index[k*IW +: IW];
      if (wr_en[k] && wi != '0) begin
        m_file[wi] = wr_data[k*WIDTH +: WIDTH];
        m_busy[wi] = 1'b0;
      end
    end
    if (acc) m_busy[rsv_index] = 1'b1;
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    rd_exp_t e;
    idle();
    model_clear();
    set_rd(0, 1'b1, 5);
    set_rd(1, 1'b1, 0);
    set_rsv(1'b1, 3);
    push_reads();
    #1;
    while (sb.size() > 0) begin
      e = sb.pop_front(); checks++;
      if (rd_data[e.port*WIDTH +: WIDTH] !== e.data || rd_valid[e.port] !== e.valid) begin
        errors++;
        $display("FAIL reset_rd p%0d: got %h/%b exp %h/%b", e.port, rd_data[e.port*WIDTH +: WIDTH], rd_valid[e.port], e.data, e.valid);
      end
    end
    checks++;
    if (busy_cnt !== 5'd0) begin errors++; $display("FAIL reset_cnt: got %0d exp 0", busy_cnt); end
    checks++;
    if (rsv_ready !== 1'b1) begin errors++; $display("FAIL reset_rsv: got %b exp 1", rsv_ready); end
    #1 reset = 1'b0;
    idle();
    tick();
    set_wr(0, 1'b1, 5, 32'hDEADBEEF);
    tick();
    idle();
    set_rsv(1'b1, 7);
    tick();
    idle();
    set_rd(0, 1'b1, 5);
    set_rd(1, 1'b1, 7);
    push_reads();
    #1;
    while (sb.size() > 0) begin
      e = sb.pop_front(); checks++;
      if (rd_data[e.port*WIDTH +: WIDTH] !== e.data || rd_valid[e.port] !== e.valid) begin
        errors++;
        $display("FAIL prerst_rd p%0d: got %h/%b exp %h/%b", e.port, rd_data[e.port*WIDTH +: WIDTH], rd_valid[e.port], e.data, e.valid);
      end
    end
    // Mid-cycle reset while a write and a reservation are presented.
    set_wr(0, 1'b1, 5, 32'h00001234);
    set_rsv(1'b1, 8);
    reset = 1'b1;
    model_clear();
    push_reads();
    #1;
    while (sb.size() > 0) begin
      e = sb.pop_front(); checks++;
      if (rd_data[e.port*WIDTH +: WIDTH] !== e.data || rd_valid[e.port] !== e.valid) begin
        errors++;
        $display("FAIL midrst_rd p%0d: got %h/%b exp %h/%b", e.port, rd_data[e.port*WIDTH +: WIDTH], rd_valid[e.port], e.data, e.valid);
      end
    end
    checks++;
    if (busy_cnt !== 5'd0) begin errors++; $display("FAIL midrst_cnt: got %0d exp 0", busy_cnt); end
    @(posedge clk);
    #1;
    push_reads();
    #1;
    while (sb.size() > 0) begin
      e = sb.pop_front(); checks++;
      if (rd_data[e.port*WIDTH +: WIDTH] !== e.data || rd_valid[e.port] !== e.valid) begin
        errors++;
        $display("FAIL heldrst_rd p%0d: got %h/%b exp %h/%b", e.port, rd_data[e.port*WIDTH +: WIDTH], rd_valid[e.port], e.data, e.valid);
      end
    end
    checks++;
    if (busy_cnt !== 5'd0) begin errors++; $display("FAIL heldrst_cnt: got %0d exp 0", busy_cnt); end
    idle();
    reset = 1'b0;
    set_rsv(1'b1, 7);
    #1;
    checks++;
    if (rsv_ready !== 1'b1) begin errors++; $display("FAIL postrst_rsv: got %b exp 1", rsv_ready); end
    idle();
  endtask

  task automatic test_write_priority();
    rd_exp_t e;
    idle();
    set_wr(0, 1'b1, 3, 32'h11);
    set_wr(1, 1'b1, 3, 32'h22);
    tick();
    idle();
    set_wr(0, 1'b1, 0, 32'hFFFF);
    tick();
    idle();
    set_rd(0, 1'b1, 0);
    set_rd(1, 1'b1, 3);
    push_reads();
    if (sb[1].data !== 32'h22) begin errors++; $display("FAIL model_prio: model %h exp 22", sb[1].data); end
    #1;
    while (sb.size() > 0) begin
      e = sb.pop_front(); checks++;
      if (rd_data[e.port*WIDTH +: WIDTH] !== e.data || rd_valid[e.port] !== e.valid) begin
        errors++;
        $display("FAIL prio_rd p%0d: got %h/%b exp %h/%b", e.port, rd_data[e.port*WIDTH +: WIDTH], rd_valid[e.port], e.data, e.valid);
      end
    end
    idle();
  endtask

  task automatic test_reserve();
    rd_exp_t e;
    idle();
    set_rsv(1'b1, 4);
    #1;
    checks++;
    if (rsv_ready !== 1'b1) begin errors++; $display("FAIL rsv4_ready: got %b exp 1", rsv_ready); end
    tick();
    idle();
    set_rsv(1'b1, 4);
    set_rd(0, 1'b1, 4);
    push_reads();
    #1;
    checks++;
    if (rsv_ready !== 1'b0) begin errors++; $display("FAIL rsv4_again: got %b exp 0", rsv_ready); end
    checks++;
    if (busy_cnt !== 5'd1) begin errors++; $display("FAIL rsv4_cnt: got %0d exp 1", busy_cnt); end
    while (sb.size() > 0) begin
      e = sb.pop_front(); checks++;
      if (rd_data[e.port*WIDTH +: WIDTH] !== e.data || rd_valid[e.port] !== e.valid) begin
        errors++;
        $display("FAIL rsv4_rd p%0d: got %h/%b exp %h/%b", e.port, rd_data[e.port*WIDTH +: WIDTH], rd_valid[e.port], e.data, e.valid);
      end
    end
    tick();
    idle();
    set_wr(1, 1'b1, 4, 32'h1234);
    tick();
    idle();
    set_rd(1, 1'b1, 4);
    push_reads();
    #1;
    checks++;
    if (busy_cnt !== 5'd0) begin errors++; $display("FAIL wb4_cnt: got %0d exp 0", busy_cnt); end
    while (sb.size() > 0) begin
      e = sb.pop_front(); checks++;
      if (rd_data[e.port*WIDTH +: WIDTH] !== e.data || rd_valid[e.port] !== e.valid) begin
        errors++;
        $display("FAIL wb4_rd p%0d: got %h/%b exp %h/%b", e.port, rd_data[e.port*WIDTH +: WIDTH], rd_valid[e.port], e.data, e.valid);
      end
    end
    idle();
  endtask

  task automatic test_write_reserve_same();
    rd_exp_t e;
    idle();
    set_wr(0, 1'b1, 9, 32'hAB);
    set_rsv(1'b1, 9);
    #1;
    checks++;
    if (rsv_ready !== 1'b1) begin errors++; $display("FAIL wr_rsv9_ready: got %b exp 1", rsv_ready); end
    tick();
    idle();
    set_rd(0, 1'b1, 9);
    push_reads();
    #1;
    checks++;
    if (busy_cnt !== 5'd1) begin errors++; $display("FAIL wr_rsv9_cnt: got %0d exp 1", busy_cnt); end
    while (sb.size() > 0) begin
      e = sb.pop_front(); checks++;
      if (rd_data[e.port*WIDTH +: WIDTH] !== e.data || rd_valid[e.port] !== e.valid) begin
        errors++;
        $display("FAIL wr_rsv9_rd p%0d: got %h/%b exp %h/%b", e.port, rd_data[e.port*WIDTH +: WIDTH], rd_valid[e.port], e.data, e.valid);
      end
    end
    set_wr(0, 1'b1, 9, 32'hAB);
    tick();
    idle();
  endtask

  task automatic test_bypass();
    rd_exp_t e;
    idle();
    set_wr(0, 1'b1, 6, 32'h77);
    tick();
    idle();
    set_rsv(1'b1, 6);
    tick();
    idle();
    set_wr(1, 1'b1, 6, 32'h55);
    set_rd(0, 1'b1, 6);
    set_rd(1, 1'b1, 6);
    push_reads();
    #1;
    while (sb.size() > 0) begin
      e = sb.pop_front(); checks++;
      if (rd_data[e.port*WIDTH +: WIDTH] !== e.data || rd_valid[e.port] !== e.valid) begin
        errors++;
        $display("FAIL byp_same p%0d: got %h/%b exp %h/%b", e.port, rd_data[e.port*WIDTH +: WIDTH], rd_valid[e.port], e.data, e.valid);
      end
    end
    tick();
    idle();
    set_rd(0, 1'b1, 6);
    push_reads();
    #1;
    while (sb.size() > 0) begin
      e = sb.pop_front(); checks++;
      if (rd_data[e.port*WIDTH +: WIDTH] !== e.data || rd_valid[e.port] !== e.valid) begin
        errors++;
        $display("FAIL byp_next p%0d: got %h/%b exp %h/%b", e.port, rd_data[e.port*WIDTH +: WIDTH], rd_valid[e.port], e.data, e.valid);
      end
    end
    idle();
  endtask

  task automatic test_fill();
    rd_exp_t e;
    idle();
    for (int i = 1; i < SIZE; i++) begin
      set_rsv(1'b1, i);
      tick();
    end
    idle();
    set_rsv(1'b1, 0);
    #1;
    checks++;
    if (busy_cnt !== 5'd31) begin errors++; $display("FAIL fill_cnt: got %0d exp 31", busy_cnt); end
    checks++;
    if (rsv_ready !== 1'b0) begin errors++; $display("FAIL fill_rsv0: got %b exp 0", rsv_ready); end
    set_rsv(1'b1, 31);
    #1;
    checks++;
    if (rsv_ready !== 1'b0) begin errors++; $display("FAIL fill_rsv31: got %b exp 0", rsv_ready); end
    idle();
    set_wr(0, 1'b1, 1, 32'hA1);
    set_wr(1, 1'b1, 2, 32'hA2);
    tick();
    idle();
    set_rd(0, 1'b1, 1);
    set_rd(1, 1'b1, 3);
    push_reads();
    #1;
    checks++;
    if (busy_cnt !== 5'd29) begin errors++; $display("FAIL drain_cnt: got %0d exp 29", busy_cnt); end
    while (sb.size() > 0) begin
      e = sb.pop_front(); checks++;
      if (rd_data[e.port*WIDTH +: WIDTH] !== e.data || rd_valid[e.port] !== e.valid) begin
        errors++;
        $display("FAIL drain_rd p%0d: got %h/%b exp %h/%b", e.port, rd_data[e.port*WIDTH +: WIDTH], rd_valid[e.port], e.data, e.valid);
      end
    end
    idle();
  endtask

  task automatic test_back_to_back();
    rd_exp_t e;
    logic exp_rdy;
    int exp_cnt;
    for (int c = 0; c < 300; c++) begin
      idle();
      for (int k = 0; k < NUM_WR; k++)
        set_wr(k, 1'($urandom_range(0, 1)), $urandom_range(0, 7), $urandom);
      for (int j = 0; j < NUM_RD; j++)
        set_rd(j, 1'($urandom_range(0, 3) != 0), $urandom_range(0, 7));
      set_rsv(1'($urandom_range(0, 1)), $urandom_range(0, 7));
      push_reads();
      exp_rdy = model_rsv_ok();
      exp_cnt = model_cnt();
      #1;
      checks++;
      if (rsv_ready !== exp_rdy) begin errors++; $display("FAIL b2b_rsv c%0d: got %b exp %b", c, rsv_ready, exp_rdy); end
      checks++;
      if (busy_cnt !== IW'(exp_cnt)) begin errors++; $display("FAIL b2b_cnt c%0d: got %0d exp %0d", c, busy_cnt, exp_cnt); end
      while (sb.size() > 0) begin
        e = sb.pop_front(); checks++;
        if (rd_data[e.port*WIDTH +: WIDTH] !== e.data || rd_valid[e.port] !== e.valid) begin
          errors++;
          $display("FAIL b2b_rd c%0d p%0d: got %h/%b exp %h/%b", c, e.port, rd_data[e.port*WIDTH +: WIDTH], rd_valid[e.port], e.data, e.valid);
        end
      end
      tick();
    end
    idle();
  endtask

  initial begin
    reset = 1'b1;
    idle();
    test_reset();
    test_write_priority();
    test_reserve();
    test_write_reserve_same();
    test_bypass();
    test_fill();
    test_back_to_back();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
